lvdc_io_master: RTL and testbench

- CPU-side initiator for the LVDC parallel I/O bus.
- Converts single-cycle internal read/write requests into timed bus cycles: 13-bit I address, 26-bit DB, active-low nIOR/nIOW strobes.
- Talks to the peripheral CPLD responder and the external GPIO latches/buffers.
- Sits between the CPU execution unit and the board I/O pins.

---
 rtl/lvdc_io_pkg.sv | 25 ++
 rtl/lvdc_io_master.sv | 177 +++++++++++++++++
 tb/tb_lvdc_io_master.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lvdc_io_pkg.sv
// Shared types and default sizing/timing for the LVDC parallel I/O bus master.
package lvdc_io_pkg;

   localparam int unsigned LVDC_IO_ADDR_W        = 13;
   localparam int unsigned LVDC_IO_DATA_W        = 26;
   localparam int unsigned LVDC_IO_SETUP_CYCLES  = 2;
   localparam int unsigned LVDC_IO_STROBE_CYCLES = 4;
   localparam int unsigned LVDC_IO_HOLD_CYCLES   = 2;
   localparam int unsigned LVDC_IO_WAIT_W        = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } lvdc_io_state_e;

   function automatic int unsigned lvdc_io_max3(input int unsigned a, input int unsigned b,
                                                input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lvdc_io_master.sv
// CPU-side initiator turning single-cycle requests into timed nIOR/nIOW bus cycles.
// Build option LVDC_IO_WAIT_EN adds io_waitb stretching and the rsp_timeout abort.
module lvdc_io_master
   import lvdc_io_pkg::*;
#(
   parameter int unsigned ADDR_W        = LVDC_IO_ADDR_W,
   parameter int unsigned DATA_W        = LVDC_IO_DATA_W,
   parameter int unsigned SETUP_CYCLES  = LVDC_IO_SETUP_CYCLES,
   parameter int unsigned STROBE_CYCLES = LVDC_IO_STROBE_CYCLES,
   parameter int unsigned HOLD_CYCLES   = LVDC_IO_HOLD_CYCLES
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] io_addr,
   output logic [DATA_W-1:0] db_out,
   output logic              db_oe,
   input  logic [DATA_W-1:0] db_in,
   output logic              nIOR,
   output logic              nIOW,
`ifdef LVDC_IO_WAIT_EN
   input  logic              io_waitb,
   output logic              rsp_timeout,
`endif
   output logic              busy
);

   localparam int unsigned MAX_CYC = lvdc_io_max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

   lvdc_io_state_e    state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] dout_d, rdata_d;
   logic              oe_d, nior_d, niow_d, rsp_valid_d, busy_d, ready_d;
`ifdef LVDC_IO_WAIT_EN
   logic [LVDC_IO_WAIT_W-1:0] wait_q, wait_d;
   logic                      tmo_q, tmo_d, rsp_timeout_d;
`endif

   // State and registered pin outputs
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         io_addr   <= '0;
         db_out    <= '0;
         db_oe     <= 1'b0;
         nIOR      <= 1'b1;
         nIOW      <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         busy      <= 1'b0;
         req_ready <= 1'b1;
`ifdef LVDC_IO_WAIT_EN
         wait_q      <= '0;
         tmo_q       <= 1'b0;
         rsp_timeout <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         io_addr   <= addr_d;
         db_out    <= dout_d;
         db_oe     <= oe_d;
         nIOR      <= nior_d;
         nIOW      <= niow_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rdata_d;
         busy      <= busy_d;
         req_ready <= ready_d;
`ifdef LVDC_IO_WAIT_EN
         wait_q      <= wait_d;
         tmo_q       <= tmo_d;
         rsp_timeout <= rsp_timeout_d;
`endif
      end
   end

   // Next-state and next-output logic sharing one phase down-counter
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      addr_d      = io_addr;
      dout_d      = db_out;
      oe_d        = db_oe;
      nior_d      = 1'b1;
      niow_d      = 1'b1;
      rsp_valid_d = 1'b0;
      rdata_d     = rsp_rdata;
`ifdef LVDC_IO_WAIT_EN
      wait_d        = wait_q;
      tmo_d         = tmo_q;
      rsp_timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               wr_d    = req_wr;
               addr_d  = req_addr;
               dout_d  = req_wdata;
               oe_d    = req_wr;
               cnt_d   = SETUP_LD;
               state_d = SETUP;
`ifdef LVDC_IO_WAIT_EN
               wait_d  = '0;
               tmo_d   = 1'b0;
`endif
            end
         end
         SETUP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               nior_d  = wr_q;
               niow_d  = !wr_q;
               cnt_d   = STROBE_LD;
               state_d = STROBE;
            end
         end
         STROBE: begin
            nior_d = wr_q;
            niow_d = !wr_q;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
`ifdef LVDC_IO_WAIT_EN
            end else if (!io_waitb && (wait_q != '1)) begin
               wait_d = wait_q + LVDC_IO_WAIT_W'(1);
`endif
            end else begin
               nior_d  = 1'b1;
               niow_d  = 1'b1;
               cnt_d   = HOLD_LD;
               state_d = HOLD;
               if (!wr_q) rdata_d = db_in;
`ifdef LVDC_IO_WAIT_EN
               // Responder never released the bus: flag it and return poison data
               if (!io_waitb) begin
                  rdata_d = '1;
                  tmo_d   = 1'b1;
               end
`endif
            end
         end
         HOLD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               rsp_valid_d = 1'b1;
               oe_d        = 1'b0;
               state_d     = IDLE;
`ifdef LVDC_IO_WAIT_EN
               rsp_timeout_d = tmo_q;
               tmo_d         = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE);
   end

endmodule

// File: tb/tb_lvdc_io_master.sv
// Scoreboard bench for lvdc_io_master: random requests, bus-protocol monitor, reset abort, fast-timing instance.
module tb_lvdc_io_master;
   import lvdc_io_pkg::*;

   localparam int unsigned AW  = 13;
   localparam int unsigned DW  = 26;
   localparam int unsigned S   = 2;
   localparam int unsigned T   = 4;
   localparam int unsigned H   = 2;
   localparam int unsigned LAT = S + T + H;

   logic clk = 1'b0;
   logic rstb = 1'b0;
   always #5 clk = ~clk;

   logic          req_valid = 1'b0, req_ready, req_wr = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0, rsp_rdata, db_out, db_in = '0;
   logic [AW-1:0] io_addr;
   logic          rsp_valid, db_oe, nIOR, nIOW, busy;

   logic          f_req_valid = 1'b0, f_req_ready, f_req_wr = 1'b0;
   logic [AW-1:0] f_req_addr = '0, f_io_addr;
   logic [DW-1:0] f_req_wdata = '0, f_rsp_rdata, f_db_out;
   logic [DW-1:0] f_db_in = 26'h0ABCDEF;
   logic          f_rsp_valid, f_db_oe, f_nIOR, f_nIOW, f_busy;
`ifdef LVDC_IO_WAIT_EN
   logic io_waitb = 1'b1, rsp_timeout, f_io_waitb = 1'b1, f_rsp_timeout;
`endif

   lvdc_io_master u_dut (
      .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .io_addr(io_addr), .db_out(db_out), .db_oe(db_oe), .db_in(db_in), .nIOR(nIOR), .nIOW(nIOW),
`ifdef LVDC_IO_WAIT_EN
      .io_waitb(io_waitb), .rsp_timeout(rsp_timeout),
`endif
      .busy(busy));

   lvdc_io_master #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) u_fast (
      .clk(clk), .rstb(rstb), .req_valid(f_req_valid), .req_ready(f_req_ready), .req_wr(f_req_wr),
      .req_addr(f_req_addr), .req_wdata(f_req_wdata), .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata),
      .io_addr(f_io_addr), .db_out(f_db_out), .db_oe(f_db_oe), .db_in(f_db_in), .nIOR(f_nIOR),
      .nIOW(f_nIOW),
`ifdef LVDC_IO_WAIT_EN
      .io_waitb(f_io_waitb), .rsp_timeout(f_rsp_timeout),
`endif
      .busy(f_busy));

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rd;
      logic [DW-1:0] exp_rdata;
      int            acc;
   } txn_t;

   txn_t          exp_q[$];
   txn_t          mon_t;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            run = 0;
   logic [DW-1:0] last_rd = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Responder: returns the transaction's read word while nIOR is low, noise otherwise
   always @(negedge clk)
      db_in <= (!nIOR && exp_q.size() > 0) ? exp_q[0].rd : DW'($urandom);

   // Bus monitor and scoreboard
   always @(negedge clk) begin
      if (!rstb) begin
         run = 0;
      end else begin
         if (!nIOR || !nIOW) begin
            check("strobe_excl", 32'(nIOR | nIOW), 32'd1);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL strobe_no_txn: strobe low with no request outstanding");
            end else begin
               if (run == 0) check("setup_len", 32'(cyc - exp_q[0].acc), 32'(S));
               check("strobe_sel", 32'(nIOW), 32'(!exp_q[0].wr));
               check("io_addr", 32'(io_addr), 32'(exp_q[0].addr));
               check("db_oe", 32'(db_oe), 32'(exp_q[0].wr));
               if (exp_q[0].wr) check("db_out", 32'(db_out), 32'(exp_q[0].wdata));
            end
            run++;
         end else if (run > 0) begin
            check("strobe_len", 32'(run), 32'(T));
            run = 0;
         end
         if (rsp_valid) begin
            check("turn_strobes", 32'({nIOR, nIOW}), 32'd3);
            check("turn_oe", 32'(db_oe), 32'd0);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rsp_spurious: rsp_valid with no request outstanding");
            end else begin
               mon_t = exp_q.pop_front();
               check("latency", 32'(cyc - mon_t.acc), 32'(LAT));
               check("rsp_rdata", 32'(rsp_rdata), 32'(mon_t.exp_rdata));
            end
         end
      end
   end

   // Present a request and hold it until accepted; req_valid is left high for the caller
   task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] rd, output int acc, output logic saw_rsp);
      txn_t t;
      int   waitc = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd;
      while (!req_ready && waitc < 50) begin
         @(posedge clk); #1;
         waitc++;
      end
      saw_rsp = rsp_valid;
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: req_ready low for %0d cycles", waitc);
         acc = -1;
      end else begin
         acc         = cyc + 1;
         t.wr        = wr;
         t.addr      = a;
         t.wdata     = wd;
         t.rd        = rd;
         t.exp_rdata = wr ? last_rd : rd;
         t.acc       = acc;
         if (!wr) last_rd = rd;
         exp_q.push_back(t);
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (n - 1) @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   acc, low, lat, waitc;
      logic saw;

      repeat (3) @(posedge clk);
      #1;
      check("rst_nIOR", 32'(nIOR), 32'd1);
      check("rst_nIOW", 32'(nIOW), 32'd1);
      check("rst_db_oe", 32'(db_oe), 32'd0);
      check("rst_io_addr", 32'(io_addr), 32'd0);
      check("rst_db_out", 32'(db_out), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      rstb = 1'b1;

      // Directed write followed back-to-back by a read
      send(1'b1, 13'h0005, 26'h2ABCDEF, '0, acc, saw);
      send(1'b0, 13'h1FFF, '0, 26'h155AA55, acc, saw);
      check("b2b_accept_on_rsp", 32'(saw), 32'd1);
      idle(3);

      // Randomized traffic with random gaps (0 = back-to-back)
      for (int i = 0; i < 40; i++) begin
         int gap;
         send(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), acc, saw);
         gap = int'($urandom_range(0, 3));
         if (gap > 0) idle(gap);
      end
      idle(1);
      waitc = 0;
      while (exp_q.size() > 0 && waitc < 50) begin
         @(posedge clk);
         waitc++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);

      // Reset during the third strobe cycle of a write
      send(1'b1, 13'h0AAA, 26'h1234567, '0, acc, saw);
      @(posedge clk); #1;
      req_valid = 1'b0;
      waitc = 0;
      while (cyc < acc + int'(S) + 2 && waitc < 50) begin
         @(posedge clk); #1;
         waitc++;
      end
      check("abort_in_strobe", 32'(nIOW), 32'd0);
      rstb = 1'b0;
      @(posedge clk); #1;
      check("abort_nIOW", 32'(nIOW), 32'd1);
      check("abort_db_oe", 32'(db_oe), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      exp_q.delete();
      last_rd = '0;
      @(posedge clk); #1;
      rstb = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Minimum timing instance: 1/1/1 cycles
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         f_req_valid = 1'b1; f_req_wr = (k == 0); f_req_addr = 13'h1ABC; f_req_wdata = 26'h3000001;
         check("fast_ready", 32'(f_req_ready), 32'd1);
         acc = cyc + 1;
         @(posedge clk); #1;
         f_req_valid = 1'b0;
         low = 0;
         lat = -1;
         for (int j = 0; j < 10; j++) begin
            if ((k == 0) ? !f_nIOW : !f_nIOR) low++;
            if (f_rsp_valid && lat < 0) begin
               lat = cyc - acc;
               if (k == 1) check("fast_rdata", 32'(f_rsp_rdata), 32'h0ABCDEF);
            end
            @(posedge clk); #1;
         end
         check("fast_strobe_len", 32'(low), 32'd1);
         check("fast_latency", 32'(lat), 32'd3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
